// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply operand path.
package matmul_pkg;

    localparam int ELEM_W  = 16;
    localparam int RES_W   = 32;
    localparam int N_ELEMS = 8;
    localparam int IDX_W   = $clog2(N_ELEMS);

    // Index of the element that must carry in_last (d2).
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_LOAD    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_WAIT    = 3'd4
    } state_t;

endpackage

// File: rtl/operand_shift_reg.sv
// Shadow buffer for one frame: eight signed elements, indexed write, parallel read.
module operand_shift_reg
    import matmul_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [IDX_W-1:0]         widx,
    input  logic signed [ELEM_W-1:0] wdata,
    output logic signed [ELEM_W-1:0] q [N_ELEMS]
);

    logic signed [ELEM_W-1:0] mem [N_ELEMS];

    // Store the accepted element at its slot; contents are don't-care until a frame completes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign q = mem;

endmodule

// File: rtl/matrix_operand_loader.sv
// Collects an 8-element operand stream into A/B operand registers and sequences
// the load / compute / wait handshake with the direct multiplier.
module matrix_operand_loader
    import matmul_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ELEM_W-1:0] in_data,
    input  logic                     in_last,
    output logic signed [ELEM_W-1:0] a1,
    output logic signed [ELEM_W-1:0] b1,
    output logic signed [ELEM_W-1:0] c1,
    output logic signed [ELEM_W-1:0] d1,
    output logic signed [ELEM_W-1:0] a2,
    output logic signed [ELEM_W-1:0] b2,
    output logic signed [ELEM_W-1:0] c2,
    output logic signed [ELEM_W-1:0] d2,
    output logic                     load,
    output logic                     compute,
    input  logic                     mul_valid,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic                     timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [CNT_W-1:0]         wcnt;
    logic signed [ELEM_W-1:0] shadow [N_ELEMS];
    logic signed [ELEM_W-1:0] op     [N_ELEMS];

    logic accept;
    logic frame_ok;
    logic mul_seen;

    assign in_ready = (state == ST_COLLECT);
    assign accept   = in_valid && in_ready;
    assign frame_ok = accept && in_last && (idx == LAST_IDX);

    // The first WAIT cycle (wcnt == 0) masks a valid left over from a previous result.
    assign mul_seen = (wcnt != '0) && mul_valid;

    // Strobes decode registered state only, so in_valid never reaches load/compute.
    assign load       = (state == ST_LOAD);
    assign compute    = (state == ST_COMPUTE);
    assign frame_done = (state == ST_WAIT) && mul_seen;
    assign timeout    = (state == ST_WAIT) && (wcnt == CNT_LAST) && !mul_seen;

    operand_shift_reg u_shadow (
        .clk   (clk),
        .we    (accept),
        .widx  (idx),
        .wdata (in_data),
        .q     (shadow)
    );

    // Frame sequencer: element index, wait counter and the framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            wcnt      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_COLLECT;
                    idx   <= '0;
                end
                ST_COLLECT: begin
                    if (accept) begin
                        if (frame_ok) begin
                            state <= ST_LOAD;
                            idx   <= '0;
                        end else if (in_last || (idx == LAST_IDX)) begin
                            // Misplaced frame marker: drop the partial frame and resync.
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    state <= ST_WAIT;
                    wcnt  <= '0;
                end
                ST_WAIT: begin
                    if (mul_seen || (wcnt == CNT_LAST)) begin
                        state <= ST_COLLECT;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand registers: capture the complete frame on its final accept so they
    // are valid in the LOAD cycle; the last element bypasses the shadow buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ELEMS; i++) begin
                op[i] <= '0;
            end
        end else if (frame_ok) begin
            for (int i = 0; i < N_ELEMS - 1; i++) begin
                op[i] <= shadow[i];
            end
            op[N_ELEMS-1] <= in_data;
        end
    end

    assign a1 = op[0];
    assign b1 = op[1];
    assign c1 = op[2];
    assign d1 = op[3];
    assign a2 = op[4];
    assign b2 = op[5];
    assign c2 = op[6];
    assign d2 = op[7];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: stimulus queues expected strobes,
// a negedge monitor pops and compares whenever the DUT raises one.
module tb_matrix_operand_loader;

    localparam int EV_LOAD = 0;
    localparam int EV_COMP = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;
    localparam int EV_TMO  = 4;

    typedef logic [7:0][15:0] ops_t;

    typedef struct packed {
        int   kind;
        int   cyc;
        ops_t ops;
    } exp_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic signed [15:0] in_data;
    logic in_last;
    logic signed [15:0] a1, b1, c1, d1, a2, b2, c2, d2;
    logic load, compute, mul_valid, frame_done, frame_err, timeout;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    ops_t act;

    matrix_operand_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .a1         (a1),
        .b1         (b1),
        .c1         (c1),
        .d1         (d1),
        .a2         (a2),
        .b2         (b2),
        .c2         (c2),
        .d2         (d2),
        .load       (load),
        .compute    (compute),
        .mul_valid  (mul_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    assign act = {d2, c2, b2, a2, d1, c1, b1, a1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_LOAD: return "load";
            EV_COMP: return "compute";
            EV_DONE: return "frame_done";
            EV_ERR:  return "frame_err";
            default: return "timeout";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input ops_t v);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.ops  = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: pulse at cyc %0d, expected no pulse", kname(kind), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                errors++;
                $display("FAIL seq_%s: got %s at cyc %0d, expected %s at cyc %0d",
                         kname(kind), kname(kind), cyc, kname(e.kind), e.cyc);
            end else if (kind == EV_LOAD && act !== e.ops) begin
                errors++;
                $display("FAIL load_ops: got %h expected %h", act, e.ops);
            end
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the scoreboard.
    always @(negedge clk) begin
        if (load && compute) begin
            checks++;
            errors++;
            $display("FAIL load_compute_overlap: got both high at cyc %0d, expected exclusive", cyc);
        end
        if (load)       pop_check(EV_LOAD);
        if (compute)    pop_check(EV_COMP);
        if (frame_done) pop_check(EV_DONE);
        if (frame_err)  pop_check(EV_ERR);
        if (timeout)    pop_check(EV_TMO);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one element; returns the cycle index of the accepting edge.
    task automatic send_elem(input logic [15:0] d, input logic last, output int e);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick(1);
        e        = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input ops_t v, output int e);
        for (int i = 0; i < 8; i++) begin
            send_elem(v[i], (i == 7), e);
        end
        push(EV_LOAD, e, v);
        push(EV_COMP, e + 1, '0);
    endtask

    // Complete a frame with mul_valid raised in WAIT cycle (2 + extra).
    task automatic finish_done(input int e, input int extra);
        tick(3 + extra);
        mul_valid = 1'b1;
        push(EV_DONE, e + 3 + extra, '0);
        tick(1);
        mul_valid = 1'b0;
        chk("collect_after_done", in_ready, 1);
    endtask

    initial begin
        int   e;
        ops_t v;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mul_valid = 1'b0;
        tick(3);
        chk("rst_ops", act, '0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_strobes", {load, compute, frame_done, frame_err, timeout}, 0);
        rst = 1'b0;
        chk("idle_in_ready", in_ready, 0);
        tick(1);
        chk("collect_in_ready", in_ready, 1);

        // Ascending frame 1..8, result valid in the second WAIT cycle.
        v = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        send_frame(v, e);
        finish_done(e, 0);

        // Mixed-sign frame passes through unmodified; result arrives later.
        v = {16'hFFF8, 16'd7, 16'hFFFA, 16'd5, 16'd4, 16'hFFFD, 16'd2, 16'hFFFF};
        send_frame(v, e);
        finish_done(e, 3);

        // in_last on the 5th element: frame dropped, no load.
        for (int i = 0; i < 5; i++) send_elem(16'(i + 50), (i == 4), e);
        push(EV_ERR, e, '0);
        tick(1);
        chk("ops_kept_after_err", act, {16'hFFF8, 16'd7, 16'hFFFA, 16'd5, 16'd4, 16'hFFFD, 16'd2, 16'hFFFF});
        // Eight elements without in_last: error on the 8th.
        for (int i = 0; i < 8; i++) send_elem(16'(i + 60), 1'b0, e);
        push(EV_ERR, e, '0);
        // Clean frame afterwards loads from a1.
        v = {16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd10};
        send_frame(v, e);
        finish_done(e, 0);

        // No result: timeout in the 16th WAIT cycle, operands held.
        v = {16'h7FFF, 16'h8000, 16'd300, 16'hFED4, 16'd0, 16'd1, 16'hFFFF, 16'd42};
        send_frame(v, e);
        push(EV_TMO, e + 17, '0);
        tick(6);
        chk("wait_in_ready", in_ready, 0);
        tick(12);
        chk("tmo_in_ready", in_ready, 1);
        chk("tmo_ops_held", act, v);

        // Stale mul_valid held high and in_valid driven during WAIT.
        mul_valid = 1'b1;
        v = {16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18};
        send_frame(v, e);
        push(EV_DONE, e + 3, '0);
        tick(2);
        in_valid = 1'b1; in_data = 16'sd99; in_last = 1'b1;
        chk("wait1_in_ready", in_ready, 0);
        tick(2);
        in_valid = 1'b0; in_last = 1'b0; mul_valid = 1'b0;
        chk("stale_ops_held", act, v);

        // Reset after three accepts: everything cleared, nothing pulses.
        for (int i = 0; i < 3; i++) send_elem(16'(i + 1), 1'b0, e);
        rst = 1'b1;
        tick(1);
        chk("midrst_ops", act, '0);
        chk("midrst_strobes", {in_ready, load, compute, frame_done, frame_err, timeout}, 0);
        rst = 1'b0;
        tick(1);
        v = {16'd28, 16'd27, 16'd26, 16'd25, 16'd24, 16'd23, 16'd22, 16'd21};
        send_frame(v, e);
        tick(2);
        // Reset while in WAIT: frame abandoned silently.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mul_valid = 1'b1;
        tick(3);
        mul_valid = 1'b0;
        chk("waitrst_ops", act, '0);
        chk("waitrst_in_ready", in_ready, 1);

        tick(4);
        chk("scoreboard_empty", 128'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
